mem_access_unit: RTL and testbench



---
 rtl/mem_access_unit.sv | 254 +++++++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit: byte-serial load/store engine for the MEM stage.
// It accepts one request at a time and splits it into 1-byte beats on an
// 8-bit synchronous RAM port. Load bytes are assembled LSB-first and then
// sign- or zero-extended. Each request gets a one-cycle response tagged with
// the destination register.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   req_valid/req_ready             request handshake (ready == engine idle)
//   req_we/size/unsigned/addr/wdata/wd  request payload
//   rsp_valid/rdata/wd/wreg/err     registered one-cycle response
//   mem_ce/we/addr/wdata            registered RAM beat outputs
//   mem_rdata                       RAM read byte, one cycle after its beat
module mem_access_unit #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned ADDR_W      = 32,
    parameter bit          MISALIGN_OK = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    input  logic [4:0]        req_wd,
    output logic              rsp_valid,
    output logic [XLEN-1:0]   rsp_rdata,
    output logic [4:0]        rsp_wd,
    output logic              rsp_wreg,
    output logic              rsp_err,
    output logic              mem_ce,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);

    localparam int unsigned ACC_W = 64;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, RESP} state_e;

    state_e            state_q, state_d;
    logic [2:0]        k_q, k_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [4:0]        wd_q, wd_d;
    logic              rd_pend_q, rd_pend_d;
    logic [2:0]        rd_idx_q, rd_idx_d;
    logic [ACC_W-1:0]  acc_q, acc_d;

    logic              ready_q, ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [XLEN-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [4:0]        rsp_wd_q, rsp_wd_d;
    logic              rsp_wreg_q, rsp_wreg_d;
    logic              rsp_err_q, rsp_err_d;
    logic              mem_ce_q, mem_ce_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]        mem_wdata_q, mem_wdata_d;

    logic              illegal_c;

    // Index of the last beat (N-1); this is also the alignment mask
    function automatic logic [2:0] last_beat(input logic [1:0] size);
        case (size)
            2'd0:    return 3'd0;
            2'd1:    return 3'd1;
            2'd2:    return 3'd3;
            default: return 3'd7;
        endcase
    endfunction

    // Extend the low 8*2^size bits of the accumulator to XLEN
    function automatic logic [XLEN-1:0] extend(input logic [ACC_W-1:0] acc,
                                               input logic [1:0] size,
                                               input logic uns);
        logic            fill;
        logic [XLEN-1:0] res;
        int unsigned     nbits;
        nbits = 32'd8 << size;
        case (size)
            2'd0:    fill = acc[7];
            2'd1:    fill = acc[15];
            2'd2:    fill = acc[31];
            default: fill = acc[63];
        endcase
        if (uns) fill = 1'b0;
        for (int unsigned i = 0; i < XLEN; i++) begin
            res[i] = (i < nbits) ? acc[i] : fill;
        end
        return res;
    endfunction

    // Illegal: doubleword on a 32-bit core, or misaligned when that is disallowed
    always_comb begin
        illegal_c = 1'b0;
        if ((XLEN != 64) && (req_size == 2'd3)) illegal_c = 1'b1;
        if (!MISALIGN_OK && ((req_addr[2:0] & last_beat(req_size)) != 3'b000)) illegal_c = 1'b1;
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        we_d        = we_q;
        size_d      = size_q;
        uns_d       = uns_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wd_d        = wd_q;
        rd_pend_d   = 1'b0;
        rd_idx_d    = k_q;
        acc_d       = acc_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = '0;
        rsp_wd_d    = '0;
        rsp_wreg_d  = 1'b0;
        rsp_err_d   = 1'b0;
        mem_ce_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = '0;
        mem_wdata_d = '0;

        // The byte for the beat issued last cycle lands in its accumulator slot
        if (rd_pend_q) acc_d[{rd_idx_q, 3'b000} +: 8] = mem_rdata;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    wd_d    = req_wd;
                    k_d     = 3'd0;
                    acc_d   = '0;
                    if (illegal_c) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_wd_d    = req_wd;
                    end else begin
                        state_d     = ISSUE;
                        mem_ce_d    = 1'b1;
                        mem_we_d    = req_we;
                        mem_addr_d  = req_addr;
                        mem_wdata_d = req_wdata[7:0];
                    end
                end
            end
            ISSUE: begin
                rd_pend_d = !we_q;
                if (k_q == last_beat(size_q)) begin
                    if (we_q) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_wd_d    = wd_q;
                    end else begin
                        state_d = DRAIN;
                    end
                end else begin
                    k_d         = k_q + 3'd1;
                    mem_ce_d    = 1'b1;
                    mem_we_d    = we_q;
                    mem_addr_d  = addr_q + ADDR_W'(k_d);
                    mem_wdata_d = 8'(wdata_q >> {k_d, 3'b000});
                end
            end
            DRAIN: begin
                state_d     = RESP;
                rsp_valid_d = 1'b1;
                rsp_wd_d    = wd_q;
                rsp_wreg_d  = 1'b1;
                rsp_rdata_d = extend(acc_d, size_q, uns_q);
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        ready_d = (state_d == IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            k_q         <= '0;
            we_q        <= 1'b0;
            size_q      <= '0;
            uns_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wd_q        <= '0;
            rd_pend_q   <= 1'b0;
            rd_idx_q    <= '0;
            acc_q       <= '0;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_wd_q    <= '0;
            rsp_wreg_q  <= 1'b0;
            rsp_err_q   <= 1'b0;
            mem_ce_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            we_q        <= we_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wd_q        <= wd_d;
            rd_pend_q   <= rd_pend_d;
            rd_idx_q    <= rd_idx_d;
            acc_q       <= acc_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_wd_q    <= rsp_wd_d;
            rsp_wreg_q  <= rsp_wreg_d;
            rsp_err_q   <= rsp_err_d;
            mem_ce_q    <= mem_ce_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign req_ready = ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_wd    = rsp_wd_q;
    assign rsp_wreg  = rsp_wreg_q;
    assign rsp_err   = rsp_err_q;
    assign mem_ce    = mem_ce_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit. Instance A is XLEN=32 with
// misalignment disallowed; instance B is XLEN=64 with misalignment allowed.
// Both share a preloaded byte RAM image (reads only; store beats are checked
// directly on the port).
module tb_mem_access_unit;

    logic        clk;
    logic        rst_n;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [63:0] req_wdata;
    logic [4:0]  req_wd;

    logic        a_req_valid, a_req_ready, a_rsp_valid, a_rsp_wreg, a_rsp_err;
    logic [31:0] a_rsp_rdata;
    logic [4:0]  a_rsp_wd;
    logic        a_mem_ce, a_mem_we;
    logic [31:0] a_mem_addr;
    logic [7:0]  a_mem_wdata, a_mem_rdata;

    logic        b_req_valid, b_req_ready, b_rsp_valid, b_rsp_wreg, b_rsp_err;
    logic [63:0] b_rsp_rdata;
    logic [4:0]  b_rsp_wd;
    logic        b_mem_ce, b_mem_we;
    logic [31:0] b_mem_addr;
    logic [7:0]  b_mem_wdata, b_mem_rdata;

    logic [7:0]  init_mem [0:1023];

    int n_vec;
    int n_err;

    // Per-cycle samples of the selected instance (index = cycle after acceptance)
    logic        s_ce   [0:15];
    logic        s_we   [0:15];
    logic [31:0] s_addr [0:15];
    logic [7:0]  s_wdat [0:15];
    logic        s_rv   [0:15];
    logic [63:0] s_rd   [0:15];
    logic [4:0]  s_wd   [0:15];
    logic        s_wreg [0:15];
    logic        s_err  [0:15];
    logic        s_rdy  [0:15];

    mem_access_unit #(.XLEN(32), .ADDR_W(32), .MISALIGN_OK(1'b0)) u_a (
        .clk(clk), .rst_n(rst_n),
        .req_valid(a_req_valid), .req_ready(a_req_ready),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata[31:0]), .req_wd(req_wd),
        .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata), .rsp_wd(a_rsp_wd),
        .rsp_wreg(a_rsp_wreg), .rsp_err(a_rsp_err),
        .mem_ce(a_mem_ce), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
        .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata)
    );

    mem_access_unit #(.XLEN(64), .ADDR_W(32), .MISALIGN_OK(1'b1)) u_b (
        .clk(clk), .rst_n(rst_n),
        .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wd(req_wd),
        .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .rsp_wd(b_rsp_wd),
        .rsp_wreg(b_rsp_wreg), .rsp_err(b_rsp_err),
        .mem_ce(b_mem_ce), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous RAM read port: byte appears the cycle after the beat
    always @(posedge clk) begin
        a_mem_rdata <= init_mem[a_mem_addr[9:0]];
        b_mem_rdata <= init_mem[b_mem_addr[9:0]];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic sample(input bit sel, input int c);
        if (sel) begin
            s_ce[c] = b_mem_ce;   s_we[c] = b_mem_we;     s_addr[c] = b_mem_addr;
            s_wdat[c] = b_mem_wdata; s_rv[c] = b_rsp_valid; s_rd[c] = b_rsp_rdata;
            s_wd[c] = b_rsp_wd;   s_wreg[c] = b_rsp_wreg; s_err[c] = b_rsp_err;
            s_rdy[c] = b_req_ready;
        end else begin
            s_ce[c] = a_mem_ce;   s_we[c] = a_mem_we;     s_addr[c] = a_mem_addr;
            s_wdat[c] = a_mem_wdata; s_rv[c] = a_rsp_valid; s_rd[c] = 64'(a_rsp_rdata);
            s_wd[c] = a_rsp_wd;   s_wreg[c] = a_rsp_wreg; s_err[c] = a_rsp_err;
            s_rdy[c] = a_req_ready;
        end
    endtask

    // Present one request for one cycle, then sample cycles 1..ncyc
    task automatic run(input bit sel, input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [63:0] wdata,
                       input logic [4:0] wd, input int ncyc);
        @(negedge clk);
        req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata; req_wd = wd;
        sample(sel, 0);
        if (sel) b_req_valid = 1'b1; else a_req_valid = 1'b1;
        @(posedge clk);
        #1;
        a_req_valid = 1'b0;
        b_req_valid = 1'b0;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            sample(sel, c);
        end
    endtask

    initial begin
        int          cnt;
        logic [31:0] ea;
        logic [7:0]  eb;
        logic [63:0] sw_data;

        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        a_req_valid = 1'b0;
        b_req_valid = 1'b0;
        req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = '0; req_wdata = '0; req_wd = '0;
        for (int i = 0; i < 1024; i++) init_mem[i] = 8'h00;
        init_mem[10'h100] = 8'h78; init_mem[10'h101] = 8'h56;
        init_mem[10'h102] = 8'h34; init_mem[10'h103] = 8'h12;
        init_mem[10'h104] = 8'h9A;
        init_mem[10'h007] = 8'h80;
        init_mem[10'h010] = 8'hA5;
        init_mem[10'h020] = 8'h34; init_mem[10'h021] = 8'h92;
        init_mem[10'h3FC] = 8'h01; init_mem[10'h3FD] = 8'h02;
        init_mem[10'h3FE] = 8'h03; init_mem[10'h3FF] = 8'h04;
        init_mem[10'h000] = 8'h05; init_mem[10'h001] = 8'h06;
        init_mem[10'h002] = 8'h07; init_mem[10'h003] = 8'h08;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_a_ready", 64'(a_req_ready), 64'h1);
        chk("rst_a_ce",    64'(a_mem_ce),    64'h0);
        chk("rst_a_rv",    64'(a_rsp_valid), 64'h0);
        chk("rst_a_addr",  64'(a_mem_addr),  64'h0);
        chk("rst_b_ready", 64'(b_req_ready), 64'h1);
        chk("rst_b_rdata", b_rsp_rdata,      64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset in the middle of a load: LW 0x100, reset in cycle 3
        @(negedge clk);
        req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
        req_addr = 32'h100; req_wdata = '0; req_wd = 5'd4;
        a_req_valid = 1'b1;
        @(posedge clk);
        #1;
        a_req_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("midrst_ce_before", 64'(a_mem_ce), 64'h1);
        rst_n = 1'b0;
        #1;
        chk("midrst_ce",    64'(a_mem_ce),    64'h0);
        chk("midrst_ready", 64'(a_req_ready), 64'h1);
        chk("midrst_addr",  64'(a_mem_addr),  64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (a_rsp_valid || a_mem_ce) cnt++;
        end
        chk("midrst_quiet", 64'(cnt), 64'h0);

        // LB 0x10 after the reset completes in 3 cycles
        run(1'b0, 1'b0, 2'd0, 1'b0, 32'h10, 64'h0, 5'd9, 4);
        chk("lb10_rdy0",  64'(s_rdy[0]), 64'h1);
        chk("lb10_ce1",   64'(s_ce[1]),  64'h1);
        chk("lb10_addr1", 64'(s_addr[1]), 64'h10);
        chk("lb10_rv2",   64'(s_rv[2]),  64'h0);
        chk("lb10_rv3",   64'(s_rv[3]),  64'h1);
        chk("lb10_rd3",   s_rd[3],       64'hFFFF_FFA5);
        chk("lb10_wd3",   64'(s_wd[3]),  64'd9);

        // LW aligned
        run(1'b0, 1'b0, 2'd2, 1'b0, 32'h100, 64'h0, 5'd5, 7);
        for (int c = 1; c <= 4; c++) begin
            ea = 32'h100 + 32'(c - 1);
            chk($sformatf("lw_ce_c%0d", c),   64'(s_ce[c]),   64'h1);
            chk($sformatf("lw_we_c%0d", c),   64'(s_we[c]),   64'h0);
            chk($sformatf("lw_addr_c%0d", c), 64'(s_addr[c]), 64'(ea));
        end
        chk("lw_ce5",   64'(s_ce[5]),   64'h0);
        chk("lw_rv5",   64'(s_rv[5]),   64'h0);
        chk("lw_rv6",   64'(s_rv[6]),   64'h1);
        chk("lw_rd6",   s_rd[6],        64'h1234_5678);
        chk("lw_wd6",   64'(s_wd[6]),   64'd5);
        chk("lw_wreg6", 64'(s_wreg[6]), 64'h1);
        chk("lw_err6",  64'(s_err[6]),  64'h0);
        chk("lw_rdy6",  64'(s_rdy[6]),  64'h0);
        chk("lw_rdy7",  64'(s_rdy[7]),  64'h1);
        chk("lw_rv7",   64'(s_rv[7]),   64'h0);
        chk("lw_rd7",   s_rd[7],        64'h0);

        // LB vs LBU of 0x80
        run(1'b0, 1'b0, 2'd0, 1'b0, 32'h7, 64'h0, 5'd1, 3);
        chk("lb7_rv3", 64'(s_rv[3]), 64'h1);
        chk("lb7_rd3", s_rd[3],      64'hFFFF_FF80);
        run(1'b0, 1'b0, 2'd0, 1'b1, 32'h7, 64'h0, 5'd2, 3);
        chk("lbu7_rv3", 64'(s_rv[3]), 64'h1);
        chk("lbu7_rd3", s_rd[3],      64'h0000_0080);

        // Misaligned LW with misalignment disallowed
        run(1'b0, 1'b0, 2'd2, 1'b0, 32'h102, 64'h0, 5'd6, 3);
        cnt = 0;
        for (int c = 1; c <= 3; c++) if (s_ce[c]) cnt++;
        chk("mis_rv1",   64'(s_rv[1]),   64'h1);
        chk("mis_err1",  64'(s_err[1]),  64'h1);
        chk("mis_wreg1", 64'(s_wreg[1]), 64'h0);
        chk("mis_rd1",   s_rd[1],        64'h0);
        chk("mis_wd1",   64'(s_wd[1]),   64'd6);
        chk("mis_noce",  64'(cnt),       64'h0);
        chk("mis_rv2",   64'(s_rv[2]),   64'h0);
        chk("mis_rdy2",  64'(s_rdy[2]),  64'h1);

        // Doubleword on a 32-bit core is illegal even when aligned
        run(1'b0, 1'b0, 2'd3, 1'b0, 32'h200, 64'h0, 5'd3, 2);
        chk("ld32_err1", 64'(s_err[1]), 64'h1);
        chk("ld32_ce1",  64'(s_ce[1]),  64'h0);

        // Aligned SW on instance A
        run(1'b0, 1'b1, 2'd2, 1'b0, 32'h40, 64'hDEAD_BEEF, 5'd7, 6);
        sw_data = 64'hDEAD_BEEF;
        for (int c = 1; c <= 4; c++) begin
            eb = 8'(sw_data >> (8 * (c - 1)));
            chk($sformatf("sw_ce_c%0d", c),   64'(s_ce[c]),   64'h1);
            chk($sformatf("sw_we_c%0d", c),   64'(s_we[c]),   64'h1);
            chk($sformatf("sw_addr_c%0d", c), 64'(s_addr[c]), 64'(32'h40 + 32'(c - 1)));
            chk($sformatf("sw_dat_c%0d", c),  64'(s_wdat[c]), 64'(eb));
        end
        chk("sw_rv4",   64'(s_rv[4]),   64'h0);
        chk("sw_rv5",   64'(s_rv[5]),   64'h1);
        chk("sw_wreg5", 64'(s_wreg[5]), 64'h0);
        chk("sw_rd5",   s_rd[5],        64'h0);
        chk("sw_ce5",   64'(s_ce[5]),   64'h0);

        // SH misaligned, allowed on instance B
        run(1'b1, 1'b1, 2'd1, 1'b0, 32'h203, 64'hABCD, 5'd8, 4);
        chk("sh_ce1",   64'(s_ce[1]),   64'h1);
        chk("sh_we1",   64'(s_we[1]),   64'h1);
        chk("sh_addr1", 64'(s_addr[1]), 64'h203);
        chk("sh_dat1",  64'(s_wdat[1]), 64'hCD);
        chk("sh_addr2", 64'(s_addr[2]), 64'h204);
        chk("sh_dat2",  64'(s_wdat[2]), 64'hAB);
        chk("sh_ce3",   64'(s_ce[3]),   64'h0);
        chk("sh_we3",   64'(s_we[3]),   64'h0);
        chk("sh_rv3",   64'(s_rv[3]),   64'h1);
        chk("sh_wreg3", 64'(s_wreg[3]), 64'h0);
        chk("sh_err3",  64'(s_err[3]),  64'h0);
        chk("sh_wd3",   64'(s_wd[3]),   64'd8);

        // LD across the top of the address space
        run(1'b1, 1'b0, 2'd3, 1'b0, 32'hFFFF_FFFC, 64'h0, 5'd10, 11);
        for (int c = 1; c <= 8; c++) begin
            ea = 32'hFFFF_FFFC + 32'(c - 1);
            chk($sformatf("ld_ce_c%0d", c),   64'(s_ce[c]),   64'h1);
            chk($sformatf("ld_addr_c%0d", c), 64'(s_addr[c]), 64'(ea));
        end
        chk("ld_ce9",   64'(s_ce[9]),   64'h0);
        chk("ld_rv9",   64'(s_rv[9]),   64'h0);
        chk("ld_rv10",  64'(s_rv[10]),  64'h1);
        chk("ld_rd10",  s_rd[10],       64'h0807_0605_0403_0201);
        chk("ld_wreg10", 64'(s_wreg[10]), 64'h1);
        chk("ld_rdy11", 64'(s_rdy[11]), 64'h1);

        // 64-bit extension: LH signed, LW misaligned signed, LWU
        run(1'b1, 1'b0, 2'd1, 1'b0, 32'h20, 64'h0, 5'd11, 4);
        chk("lh_rv4", 64'(s_rv[4]), 64'h1);
        chk("lh_rd4", s_rd[4],      64'hFFFF_FFFF_FFFF_9234);
        run(1'b1, 1'b0, 2'd2, 1'b0, 32'h101, 64'h0, 5'd12, 6);
        chk("lwm_rv6",  64'(s_rv[6]),  64'h1);
        chk("lwm_err6", 64'(s_err[6]), 64'h0);
        chk("lwm_rd6",  s_rd[6],       64'hFFFF_FFFF_9A12_3456);
        run(1'b1, 1'b0, 2'd2, 1'b1, 32'h101, 64'h0, 5'd13, 6);
        chk("lwu_rd6", s_rd[6], 64'h0000_0000_9A12_3456);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
